mdu_hilo: RTL and testbench
===========================

Name: mdu_hilo

Overview:
- Multi-cycle multiply/accumulate unit in the EX stage. It sequences operands into the team's combinational 32x32 booth-2 multiplier `mul_booth2` (ports a, b, sign, result[63:0]), registers the product, and owns the architectural HI/LO registers.
- Implements MULT/MULTU/MADD/MADDU/MSUB/MSUBU/MTHI/MTLO.
- While an operation is in flight it drives `busy`, which the pipeline uses to stall EX.

Parameters:
- None. All widths are fixed at 32-bit operands and a 64-bit HI:LO.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  EX presents an MDU op this cycle
- req_op  in  4  0 NOP, 1 MULT, 2 MULTU, 3 MADD, 4 MADDU, 5 MSUB, 6 MSUBU, 7 MTHI, 8 MTLO, 9 MUL (optional), 10-15 NOP
- src_a  in  32  rs operand
- src_b  in  32  rt operand
- flush  in  1  exception/flush; kills the in-flight op
- req_ready  out  1  high when state==IDLE
- busy  out  1  high when state!=IDLE
- done  out  1  one-cycle pulse in the WB-state cycle of a completed mult-class op
- hi_o  out  32  architectural HI
- lo_o  out  32  architectural LO
- gpr_valid  out  1  MUL result valid pulse (optional feature)
- gpr_result  out  32  MUL result (optional feature)

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; hi/lo=0; a_q, b_q, op_q, prod_q=0.
  - done=0, gpr_valid=0, gpr_result=0.
  - Reset mid-operation aborts the op with no HI/LO write.
- Accept: the op is accepted when req_valid & req_ready & ~flush; `sign`=1 for ops 1, 3, 5, 9.
- States: IDLE -> MUL -> WB -> IDLE.
- Cycle T (IDLE, accept of ops 1-6, 9): latch a_q, b_q, op_q, sign_q; next state MUL.
- Cycle T+1 (MUL): drive `mul_booth2` from a_q, b_q, sign_q; prod_q <= result at the edge; next state WB.
- Cycle T+2 (WB): done=1.
  - MULT/MULTU: {hi,lo} <= prod_q.
  - MADD/MADDU: {hi,lo} <= {hi,lo} + prod_q.
  - MSUB/MSUBU: {hi,lo} <= {hi,lo} - prod_q.
  - All arithmetic is 64-bit modulo 2^64; the accumulator uses HI/LO as held in the WB cycle.
  - Next state IDLE.
  - New hi_o/lo_o are visible from T+3; req_ready is high again at T+3.
- MTHI/MTLO: accepted in IDLE; at the accept edge hi<=src_a or lo<=src_a (the other half is unchanged); state stays IDLE; no done pulse.
- NOP and undefined ops: accepted with no effect; no state change.
- req_valid while busy: ignored. EX is stalled on busy, so the request is re-presented.
- Flush:
  - flush=1 in MUL or WB: next state IDLE; no HI/LO write; done=0 (flush in WB overrides the write).
  - flush=1 in IDLE: any request that cycle is dropped, including MTHI/MTLO.
- Simultaneous rst and flush: reset wins.
- hi_o/lo_o are register outputs with no forwarding of pending writes.

Optional Feature:
- Macro: MDU_MUL_GPR_EN.
- Defined: op 9 (MUL) follows the same MUL->WB path.
  - In WB: gpr_valid=1 and gpr_result=prod_q[31:0]; HI/LO are untouched; done=1.
  - gpr_result holds its value until the next MUL completes.
  - Flush in MUL or WB: no gpr_valid pulse.
- Undefined: op 9 is treated as NOP; gpr_valid and gpr_result are tied to 0.

Test Plan:
- MULT a=0xFFFFFFFF b=0x00000002, accept at T -> done at T+2; HI=0xFFFFFFFF, LO=0xFFFFFFFE at T+3; busy high T+1..T+2.
- MULTU a=0xFFFFFFFF b=0x00000002 -> HI=0x00000001, LO=0xFFFFFFFE.
- Sequence MTHI 0, MTLO 10, MADD 3,4 -> HI=0, LO=22. Then MSUBU 0xFFFFFFFF,1 -> HI=0xFFFFFFFF, LO=0x00000017.
- HI:LO=0x1:0x2, MULT 5,5 with flush=1 in the WB cycle -> HI=0x1, LO=0x2, done=0, req_ready=1 next cycle. Repeat with rst=1 in MUL -> HI=LO=0, state IDLE.
- During a busy MULT, drive req_valid with MTLO 0xAAAA -> ignored, LO holds the MULT result. MTHI with flush=1 in IDLE -> HI unchanged.
- With MDU_MUL_GPR_EN: MUL a=0xFFFFFFFD b=7 -> gpr_valid pulse at T+2, gpr_result=0xFFFFFFEB, HI/LO unchanged. Without the macro: same stimulus -> gpr_valid stays 0, busy never asserts.

Source files
------------

// File: rtl/mdu_hilo.sv
// Multi-cycle MULT/MADD/MSUB unit that owns HI/LO, plus the radix-4 Booth multiplier it drives.
// Define MDU_MUL_GPR_EN to enable op 9 (MUL), which writes a GPR result instead of HI/LO.

module mul_booth2 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        sign,
   output logic [63:0] result
);
   logic [63:0] w_ax;
   logic [34:0] w_bx;

   // Extend b to 34 bits so unsigned operands stay positive, then append the implicit 0
   assign w_ax = {{32{sign & a[31]}}, a};
   assign w_bx = {{2{sign & b[31]}}, b, 1'b0};

   always_comb begin
      logic [63:0] w_acc;
      logic [63:0] w_pp;
      w_acc = '0;
      for (int i = 0; i < 17; i++) begin
         w_pp = '0;
         case (w_bx[2*i +: 3])
            3'b001, 3'b010: w_pp = w_ax;
            3'b011:         w_pp = w_ax << 1;
            3'b100:         w_pp = -(w_ax << 1);
            3'b101, 3'b110: w_pp = -w_ax;
            default:        w_pp = '0;
         endcase
         w_acc = w_acc + (w_pp << (2 * i));
      end
      result = w_acc;
   end
endmodule

module mdu_hilo (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [3:0]  req_op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   output logic        req_ready,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        gpr_valid,
   output logic [31:0] gpr_result
);
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_WB} state_t;

   state_t      r_state;
   logic [31:0] r_hi, r_lo, r_a, r_b;
   logic [3:0]  r_op;
   logic        r_sign;
   logic [63:0] r_prod;
   logic [63:0] w_mul_res;
   logic [63:0] w_hilo;
   logic        w_accept, w_mult_op, w_sign;

   mul_booth2 u_mul (
      .a      (r_a),
      .b      (r_b),
      .sign   (r_sign),
      .result (w_mul_res)
   );

   assign w_accept = req_valid & (r_state == S_IDLE) & ~flush;
   assign w_hilo   = {r_hi, r_lo};
`ifdef MDU_MUL_GPR_EN
   assign w_mult_op = ((req_op >= 4'd1) && (req_op <= 4'd6)) || (req_op == 4'd9);
   assign w_sign    = (req_op == 4'd1) || (req_op == 4'd3) || (req_op == 4'd5) || (req_op == 4'd9);
`else
   assign w_mult_op = (req_op >= 4'd1) && (req_op <= 4'd6);
   assign w_sign    = (req_op == 4'd1) || (req_op == 4'd3) || (req_op == 4'd5);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_hi    <= '0;
         r_lo    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_op    <= '0;
         r_sign  <= 1'b0;
         r_prod  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (w_mult_op) begin
                     r_a     <= src_a;
                     r_b     <= src_b;
                     r_op    <= req_op;
                     r_sign  <= w_sign;
                     r_state <= S_MUL;
                  end else if (req_op == 4'd7) begin
                     r_hi <= src_a;
                  end else if (req_op == 4'd8) begin
                     r_lo <= src_a;
                  end
               end
            end
            S_MUL: begin
               if (flush) begin
                  r_state <= S_IDLE;
               end else begin
                  r_prod  <= w_mul_res;
                  r_state <= S_WB;
               end
            end
            S_WB: begin
               r_state <= S_IDLE;
               if (!flush) begin
                  case (r_op)
                     4'd1, 4'd2: {r_hi, r_lo} <= r_prod;
                     4'd3, 4'd4: {r_hi, r_lo} <= w_hilo + r_prod;
                     4'd5, 4'd6: {r_hi, r_lo} <= w_hilo - r_prod;
                     default: ;
                  endcase
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign req_ready = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign done      = (r_state == S_WB) & ~flush & ~rst;
   assign hi_o      = r_hi;
   assign lo_o      = r_lo;

`ifdef MDU_MUL_GPR_EN
   logic [31:0] r_gpr;
   logic        w_gpr_wb;

   // The result is presented combinationally in WB so the pulse and data line up in the same cycle
   assign w_gpr_wb = done & (r_op == 4'd9);

   always_ff @(posedge clk) begin
      if (rst)           r_gpr <= '0;
      else if (w_gpr_wb) r_gpr <= r_prod[31:0];
   end

   assign gpr_valid  = w_gpr_wb;
   assign gpr_result = w_gpr_wb ? r_prod[31:0] : r_gpr;
`else
   assign gpr_valid  = 1'b0;
   assign gpr_result = '0;
`endif
endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: timing, HI/LO arithmetic, flush/reset aborts and the optional MUL path.
module tb_mdu_hilo;
   logic        clk = 1'b0;
   logic        rst, req_valid, flush;
   logic [3:0]  req_op;
   logic [31:0] src_a, src_b;
   logic        req_ready, busy, done, gpr_valid;
   logic [31:0] hi_o, lo_o, gpr_result;
   int checks = 0;
   int failures = 0;

   mdu_hilo dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
      .src_a(src_a), .src_b(src_b), .flush(flush),
      .req_ready(req_ready), .busy(busy), .done(done),
      .hi_o(hi_o), .lo_o(lo_o), .gpr_valid(gpr_valid), .gpr_result(gpr_result)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic present(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      req_valid = 1'b1; req_op = op; src_a = a; src_b = b;
      tick();
      req_valid = 1'b0; req_op = 4'd0;
   endtask

   task automatic test_reset;
      rst = 1'b1; req_valid = 1'b0; req_op = 4'd0; src_a = '0; src_b = '0; flush = 1'b0;
      tick(); tick();
      rst = 1'b0;
      #1;
      checks++; if (hi_o !== 32'h0 || lo_o !== 32'h0) begin failures++; $display("FAIL reset_hilo got=%h:%h exp=0:0", hi_o, lo_o); end
      checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL reset_state got ready=%b busy=%b exp 1/0", req_ready, busy); end
      checks++; if (done !== 1'b0 || gpr_valid !== 1'b0 || gpr_result !== 32'h0) begin failures++; $display("FAIL reset_outs got done=%b gv=%b gr=%h exp 0/0/0", done, gpr_valid, gpr_result); end
   endtask

   task automatic test_mult;
      present(4'd1, 32'hFFFFFFFF, 32'h00000002);  // now T+1
      #1;
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL mult_t1 got busy=%b done=%b exp 1/0", busy, done); end
      tick(); #1;
      checks++; if (busy !== 1'b1 || done !== 1'b1) begin failures++; $display("FAIL mult_t2 got busy=%b done=%b exp 1/1", busy, done); end
      tick(); #1;
      checks++; if (hi_o !== 32'hFFFFFFFF || lo_o !== 32'hFFFFFFFE) begin failures++; $display("FAIL mult_hilo got=%h:%h exp=ffffffff:fffffffe", hi_o, lo_o); end
      checks++; if (req_ready !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL mult_t3 got ready=%b done=%b exp 1/0", req_ready, done); end
   endtask

   task automatic test_multu;
      present(4'd2, 32'hFFFFFFFF, 32'h00000002);
      tick(); tick(); #1;
      checks++; if (hi_o !== 32'h00000001 || lo_o !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_hilo got=%h:%h exp=00000001:fffffffe", hi_o, lo_o); end
   endtask

   task automatic test_madd_msub;
      present(4'd7, 32'h0, 32'h0);
      present(4'd8, 32'd10, 32'h0);
      #1;
      checks++; if (hi_o !== 32'h0 || lo_o !== 32'd10 || busy !== 1'b0) begin failures++; $display("FAIL mthi_mtlo got=%h:%h busy=%b exp=0:a busy 0", hi_o, lo_o, busy); end
      present(4'd3, 32'd3, 32'd4);
      tick(); tick(); #1;
      checks++; if (hi_o !== 32'h0 || lo_o !== 32'd22) begin failures++; $display("FAIL madd_hilo got=%h:%h exp=0:16", hi_o, lo_o); end
      present(4'd6, 32'hFFFFFFFF, 32'd1);
      tick(); tick(); #1;
      checks++; if (hi_o !== 32'hFFFFFFFF || lo_o !== 32'h00000017) begin failures++; $display("FAIL msubu_hilo got=%h:%h exp=ffffffff:00000017", hi_o, lo_o); end
   endtask

   task automatic test_flush_wb;
      present(4'd7, 32'h1, 32'h0);
      present(4'd8, 32'h2, 32'h0);
      present(4'd1, 32'd5, 32'd5);
      tick();               // WB cycle
      flush = 1'b1; #1;
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL flush_wb_done got=%b exp=0", done); end
      tick(); flush = 1'b0; #1;
      checks++; if (hi_o !== 32'h1 || lo_o !== 32'h2 || req_ready !== 1'b1) begin failures++; $display("FAIL flush_wb_hilo got=%h:%h ready=%b exp=1:2 ready 1", hi_o, lo_o, req_ready); end
   endtask

   task automatic test_rst_mul;
      present(4'd1, 32'd5, 32'd5);   // MUL cycle
      rst = 1'b1;
      tick(); rst = 1'b0; #1;
      checks++; if (hi_o !== 32'h0 || lo_o !== 32'h0 || req_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL rst_mul got=%h:%h ready=%b busy=%b exp=0:0 1/0", hi_o, lo_o, req_ready, busy); end
      tick(); #1;
      checks++; if (done !== 1'b0 || lo_o !== 32'h0) begin failures++; $display("FAIL rst_mul_after got done=%b lo=%h exp 0/0", done, lo_o); end
   endtask

   task automatic test_busy_ignore;
      present(4'd1, 32'd3, 32'd4);
      req_valid = 1'b1; req_op = 4'd8; src_a = 32'h0000AAAA;
      tick(); tick();
      req_valid = 1'b0; req_op = 4'd0; #1;
      checks++; if (hi_o !== 32'h0 || lo_o !== 32'd12) begin failures++; $display("FAIL busy_ignore got=%h:%h exp=0:c", hi_o, lo_o); end
      req_valid = 1'b1; req_op = 4'd7; src_a = 32'h1234; flush = 1'b1;
      tick();
      req_valid = 1'b0; req_op = 4'd0; flush = 1'b0; #1;
      checks++; if (hi_o !== 32'h0 || busy !== 1'b0) begin failures++; $display("FAIL flush_idle got hi=%h busy=%b exp 0/0", hi_o, busy); end
      present(4'd12, 32'hDEAD, 32'hBEEF);
      #1;
      checks++; if (hi_o !== 32'h0 || lo_o !== 32'd12 || busy !== 1'b0) begin failures++; $display("FAIL nop got=%h:%h busy=%b exp=0:c 0", hi_o, lo_o, busy); end
   endtask

   task automatic test_mul_gpr;
      present(4'd9, 32'hFFFFFFFD, 32'd7);
      #1;
`ifdef MDU_MUL_GPR_EN
      checks++; if (busy !== 1'b1 || gpr_valid !== 1'b0) begin failures++; $display("FAIL mul_t1 got busy=%b gv=%b exp 1/0", busy, gpr_valid); end
      tick(); #1;
      checks++; if (gpr_valid !== 1'b1 || gpr_result !== 32'hFFFFFFEB || done !== 1'b1) begin failures++; $display("FAIL mul_t2 got gv=%b gr=%h done=%b exp 1/ffffffeb/1", gpr_valid, gpr_result, done); end
      tick(); #1;
      checks++; if (gpr_valid !== 1'b0 || gpr_result !== 32'hFFFFFFEB) begin failures++; $display("FAIL mul_hold got gv=%b gr=%h exp 0/ffffffeb", gpr_valid, gpr_result); end
`else
      checks++; if (busy !== 1'b0 || gpr_valid !== 1'b0) begin failures++; $display("FAIL mul_off_t1 got busy=%b gv=%b exp 0/0", busy, gpr_valid); end
      tick(); #1;
      checks++; if (busy !== 1'b0 || gpr_valid !== 1'b0 || gpr_result !== 32'h0) begin failures++; $display("FAIL mul_off_t2 got busy=%b gv=%b gr=%h exp 0/0/0", busy, gpr_valid, gpr_result); end
`endif
      checks++; if (hi_o !== 32'h0 || lo_o !== 32'd12) begin failures++; $display("FAIL mul_hilo got=%h:%h exp=0:c", hi_o, lo_o); end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_multu();
      test_madd_msub();
      test_flush_wb();
      test_rst_mul();
      test_busy_ignore();
      test_mul_gpr();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
